sensor_luz_sequencer: RTL
=========================

# sensor_luz_sequencer

Autonomous sampling controller for the ambient-light sensor SPI path. It drives the SPI interface's register port (write-enable, address, write data, read data) as a bus master. Each sample runs one 2-byte SPI transaction, polls for completion, reads both received bytes and extracts the 8-bit light value. It sits between the SPI interface and the CPU-visible peripheral logic, so software gets a ready value instead of hand-sequencing transfers.

## Interface
- PERIOD_CYCLES, 10_000_000: clocks between automatic samples when enable_i=1 (≥16).
- TIMEOUT_CYCLES, 65_535: maximum POLL cycles before abort (≥4).
- clk_i  input  1  system clock, all logic rising-edge.
- rst_i  input  1  asynchronous, active-low reset.
- enable_i  input  1  periodic sampling enable.
- trigger_i  input  1  one-cycle request for an immediate sample.
- we_o  output  1  register-port write enable to SPI interface.
- addr_o  output  32  register-port address; bit9=0 selects the control register, bit9=1 selects the data bank, [7:2] is the data index; all other bits 0.
- wdata_o  output  32  register-port write data.
- rdata_i  input  32  register-port read data, combinational from addr_o.
- sample_o  output  8  last light value.
- valid_o  output  1  one-cycle pulse when sample_o updates.
- busy_o  output  1  high outside IDLE.
- timeout_o  output  1  sticky abort flag.

## Operation
- Control word written: bit0=send, bits[12:4]=n_tx_end=1 (2 bytes), all other bits 0. Constant CTRL_GO=32'h0000_0011.
- The SPI interface clears bit0 when the transfer completes.
- The sensor frame is 16 bits: byte0 is data index 0, byte1 is data index 1.
- Value = {byte0[4:0], byte1[7:5]}.
- FSM states, Moore-decoded outputs:
  - IDLE: we_o=0, addr_o=0, wdata_o=0. If a request is pending, go to CFG.
  - CFG: we_o=1, addr_o=0, wdata_o=CTRL_GO. Go to POLL.
  - POLL: read addr 0. If rdata_i[0]=0, go to RD0. Else, if the poll counter equals TIMEOUT_CYCLES-1, go to ABORT. Otherwise stay in POLL.
  - RD0: addr_o=32'h200. Capture rdata_i[7:0]. Go to RD1.
  - RD1: addr_o=32'h204. Capture rdata_i[7:0]. Go to DONE.
  - DONE: load sample_o, pulse valid_o, clear timeout_o. Go to IDLE.
  - ABORT: we_o=1, addr_o=0, wdata_o=0. Set timeout_o. Go to IDLE. sample_o keeps its old value and no valid_o pulse is issued.
- Request sources:
  - trigger_i=1.
  - Period counter expiry while enable_i=1. The counter counts 0..PERIOD_CYCLES-1 and wraps.
- The period counter runs only while enable_i=1 and resets to 0 when enable_i=0.
- Requests arriving while busy set a single pending flag; multiple requests collapse to one. The flag clears on entry to CFG.
- A request in the same cycle as the DONE→IDLE transition is kept pending and serviced next.
- The poll counter resets on entry to POLL.
- Reset mid-transaction returns to IDLE immediately. No abort write is issued; the SPI interface shares the same reset.

## Timing
- Reset values: we_o=0, addr_o=0, wdata_o=0, sample_o=0, valid_o=0, busy_o=0, timeout_o=0. Pending flag, period counter and poll counter are all 0.
- trigger_i high in cycle N: CFG in N+1, first POLL in N+2.
- Latency after the first POLL read with bit0=0: RD0 +1, RD1 +2, DONE (valid_o) +3.
- Minimum trigger→valid_o: 6 cycles, when the SPI reports done on the first poll.
- Abort: ABORT is the cycle after the TIMEOUT_CYCLES-th POLL cycle. timeout_o rises the cycle after ABORT.
- valid_o is exactly 1 cycle wide, coincident with the sample_o update edge+0; both are registered.
- First periodic request: PERIOD_CYCLES cycles after enable_i rises.

## Configuration
- SENSOR_LUZ_AVG_EN defined:
  - A 10-bit accumulator and a 2-bit sample counter are added.
  - Every completed sample adds to the accumulator. valid_o pulses only on every 4th completed sample, with sample_o=acc[9:2]; the accumulator then clears.
  - An ABORT clears both the accumulator and the counter.
- Undefined: every completed sample updates sample_o directly. No accumulator logic is present.

## Test plan
- Reset, then one trigger_i. SPI model clears send after 40 cycles; byte0=8'h1A, byte1=8'hE0 → one CTRL_GO write, sample_o=8'hD7, one valid_o pulse, busy_o low after DONE.
- SPI model never clears send, TIMEOUT_CYCLES=8 → 8 POLL cycles, one write of 0 to addr 0, timeout_o=1, no valid_o. A following good sample clears timeout_o.
- enable_i=1, PERIOD_CYCLES=100, fast SPI → valid_o every 100 cycles. enable_i=0 → no further CFG writes.
- Three trigger_i pulses during one busy transaction → exactly two transactions in total.
- rst_i asserted while in POLL → all outputs at reset values asynchronously. A new trigger after release starts cleanly at CFG.
- SENSOR_LUZ_AVG_EN defined, samples 10, 20, 30, 41 → single valid_o with sample_o=25; no valid_o after the first three samples.

Source files
------------

// File: rtl/sensor_luz_sequencer.sv
// rtl/sensor_luz_sequencer.sv - ambient-light SPI sampling sequencer (register-port bus master)
// Optional 4-sample averaging is built when SENSOR_LUZ_AVG_EN is defined.
module sensor_luz_sequencer #(
  parameter int PERIOD_CYCLES  = 10_000_000,
  parameter int TIMEOUT_CYCLES = 65_535
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic        trigger_i,
  output logic        we_o,
  output logic [31:0] addr_o,
  output logic [31:0] wdata_o,
  input  logic [31:0] rdata_i,
  output logic [7:0]  sample_o,
  output logic        valid_o,
  output logic        busy_o,
  output logic        timeout_o
);

  localparam logic [31:0] CTRL_GO   = 32'h0000_0011;
  localparam logic [31:0] ADDR_CTRL = 32'h0000_0000;
  localparam logic [31:0] ADDR_D0   = 32'h0000_0200;
  localparam logic [31:0] ADDR_D1   = 32'h0000_0204;
  localparam int PW = (PERIOD_CYCLES  > 2) ? $clog2(PERIOD_CYCLES)  : 1;
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG,
    S_POLL,
    S_RD0,
    S_RD1,
    S_DONE,
    S_ABORT
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [PW-1:0] r_period_cnt;
  logic [TW-1:0] r_poll_cnt;
  logic          r_pending;
  logic [4:0]    r_byte0;
  logic [2:0]    r_byte1;
  logic          w_period_hit;
  logic          w_req;
  logic [7:0]    w_value;
  logic          w_unused_rdata;

  assign w_period_hit   = enable_i && (r_period_cnt == PW'(PERIOD_CYCLES - 1));
  assign w_req          = trigger_i | w_period_hit;
  assign w_value        = {r_byte0, r_byte1};
  assign busy_o         = (r_state != S_IDLE);
  assign w_unused_rdata = ^rdata_i[31:8];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    we_o    = 1'b0;
    addr_o  = ADDR_CTRL;
    wdata_o = 32'h0;
    case (r_state)
      S_IDLE: begin
        if (w_req || r_pending) w_next = S_CFG;
      end
      S_CFG: begin
        we_o    = 1'b1;
        wdata_o = CTRL_GO;
        w_next  = S_POLL;
      end
      S_POLL: begin
        if (!rdata_i[0]) begin
          w_next = S_RD0;
        end else if (r_poll_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          w_next = S_ABORT;
        end
      end
      S_RD0: begin
        addr_o = ADDR_D0;
        w_next = S_RD1;
      end
      S_RD1: begin
        addr_o = ADDR_D1;
        w_next = S_DONE;
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      S_ABORT: begin
        // Clearing the send bit cancels the stuck transfer in the SPI block.
        we_o   = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_period_cnt <= '0;
    end else if (!enable_i || w_period_hit) begin
      r_period_cnt <= '0;
    end else begin
      r_period_cnt <= r_period_cnt + 1'b1;
    end
  end

  // Requests seen while busy (including DONE) collapse into one pending flag.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_pending <= 1'b0;
    end else if (r_state == S_IDLE && w_next == S_CFG) begin
      r_pending <= 1'b0;
    end else if (w_req) begin
      r_pending <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_poll_cnt <= '0;
    end else if (r_state != S_POLL) begin
      r_poll_cnt <= '0;
    end else begin
      r_poll_cnt <= r_poll_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_byte0 <= '0;
      r_byte1 <= '0;
    end else begin
      if (r_state == S_RD0) r_byte0 <= rdata_i[4:0];
      if (r_state == S_RD1) r_byte1 <= rdata_i[7:5];
    end
  end

`ifdef SENSOR_LUZ_AVG_EN
  logic [9:0] r_acc;
  logic [1:0] r_avg_cnt;
  logic [9:0] w_acc_sum;

  assign w_acc_sum = r_acc + {2'b00, w_value};

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sample_o  <= '0;
      valid_o   <= 1'b0;
      timeout_o <= 1'b0;
      r_acc     <= '0;
      r_avg_cnt <= '0;
    end else begin
      valid_o <= 1'b0;
      if (r_state == S_DONE) begin
        timeout_o <= 1'b0;
        if (r_avg_cnt == 2'd3) begin
          sample_o  <= w_acc_sum[9:2];
          valid_o   <= 1'b1;
          r_acc     <= '0;
          r_avg_cnt <= '0;
        end else begin
          r_acc     <= w_acc_sum;
          r_avg_cnt <= r_avg_cnt + 1'b1;
        end
      end else if (r_state == S_ABORT) begin
        timeout_o <= 1'b1;
        r_acc     <= '0;
        r_avg_cnt <= '0;
      end
    end
  end
`else
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sample_o  <= '0;
      valid_o   <= 1'b0;
      timeout_o <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      if (r_state == S_DONE) begin
        sample_o  <= w_value;
        valid_o   <= 1'b1;
        timeout_o <= 1'b0;
      end else if (r_state == S_ABORT) begin
        timeout_o <= 1'b1;
      end
    end
  end
`endif

endmodule
